// File: rtl/serial_to_parallel_loader_if.sv
// Serial-in / parallel-out bus for serial_to_parallel_loader.
// The master drives the qualified bit stream; the slave returns the word, pulses and status.
interface serial_to_parallel_loader_if #(
  parameter int N = 4
);
  logic         sync;
  logic         din;
  logic         din_valid;
  logic [N-1:0] data;
  logic         load;
  logic         busy;
  logic         err;

  modport master (
    output sync, din, din_valid,
    input  data, load, busy, err
  );

  modport slave (
    input  sync, din, din_valid,
    output data, load, busy, err
  );
endinterface

// File: rtl/serial_to_parallel_loader.sv
// MSB-first deserializer producing an N-bit word with a one-cycle load pulse.
// Optional even-parity trailer bit enabled by defining S2P_PARITY_EN.
module serial_to_parallel_loader #(
  parameter int N = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  serial_to_parallel_loader_if.slave    bus
);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

`ifdef S2P_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [N-1:0]     data_q, data_d;
  logic             load_q, load_d;
`ifdef S2P_PARITY_EN
  logic             err_q, err_d;
`endif

  logic [N-1:0] shifted;
  assign shifted = {shreg_q[N-2:0], bus.din};

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    load_d  = 1'b0;
`ifdef S2P_PARITY_EN
    err_d   = 1'b0;
`endif
    // sync aborts the frame and drops whatever bit is on din this cycle
    if (bus.sync) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.din_valid) begin
      case (state_q)
        IDLE: begin
          shreg_d = shifted;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          shreg_d = shifted;
          if (cnt_q < LAST_IDX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
`ifdef S2P_PARITY_EN
            state_d = PAR;
`else
            data_d  = shifted;
            load_d  = 1'b1;
            state_d = IDLE;
`endif
          end
        end
`ifdef S2P_PARITY_EN
        PAR: begin
          // even parity: the data bits plus the parity bit must XOR to zero
          if (^{shreg_q, bus.din} == 1'b0) begin
            data_d = shreg_q;
            load_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
`ifdef S2P_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      load_q  <= load_d;
`ifdef S2P_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.data = data_q;
  assign bus.load = load_q;
  assign bus.busy = (state_q != IDLE);
`ifdef S2P_PARITY_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: doc/serial_to_parallel_loader.md
# serial_to_parallel_loader

Deserializer that collects an N-bit word from a qualified serial bit stream, MSB first. It presents the word on a parallel bus with a one-cycle `load` pulse. It sits directly upstream of the load-enable register stage: `data` drives the register's `I` input and `load` drives its `load` input, so the register captures each completed word and holds it between frames.

## Interface
- `N`, default 4: word width in bits; legal range N ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sync` input 1: synchronous frame restart; aborts any partial word.
- `din` input 1: serial data bit.
- `din_valid` input 1: `din` is sampled on a rising edge only when this is high.
- `data` output N: last completed word, registered; stable between `load` pulses.
- `load` output 1: registered one-cycle pulse; `data` is valid in that cycle.
- `busy` output 1: high while a frame is partially received (state ≠ IDLE).
- `err` output 1: registered one-cycle parity-failure pulse; constant 0 when parity is compiled out.

## Operation
- Internal state: N-bit shift register `shreg`, a bit counter of width $clog2(N+1), and FSM states IDLE, SHIFT and PAR (PAR exists only with parity enabled).
- Shifting is MSB first: each accepted bit updates `shreg <= {shreg[N-2:0], din}`.
- IDLE, `din_valid`=1: shift in the bit, counter = 1, go to SHIFT.
- SHIFT, `din_valid`=1 and counter < N-1: shift in the bit and increment the counter.
- SHIFT, `din_valid`=1 and counter = N-1 (last data bit), without parity:
  - `data <= {shreg[N-2:0], din}`
  - `load <= 1`
  - go to IDLE
- SHIFT, last data bit, with parity: shift in the bit and go to PAR.
- PAR, `din_valid`=1: `din` is an even-parity bit over the N data bits. Return to IDLE in both cases.
  - If XOR of `shreg` and `din` is 0: `data <= shreg`, `load <= 1`.
  - Otherwise: `err <= 1` and `data` is unchanged.
- `din_valid`=0 in any state: state, counter and `shreg` hold. Gaps of any length are legal.
- `load` and `err` are forced to 0 in every cycle in which they are not set as above.
- `sync`=1: state goes to IDLE and the counter to 0. Any `din` sampled in that cycle is discarded.
  - `sync` has priority over `din_valid`.
  - `data` is not modified; `load` and `err` are not asserted.
- `reset`=1: state IDLE, counter 0, `shreg` 0, `data` 0, `load` 0, `err` 0, `busy` 0. Reset has priority over `sync` and `din_valid`.

## Timing
- Latency: `load` (or `err`) is high in the cycle after the edge that samples the last bit of the frame. `data` updates on that same edge.
- Minimum frame length is N cycles (N+1 with parity) at `din_valid`=1 continuously.
- Back-to-back frames are supported with no dead cycle. The first bit of the next frame may be sampled on the edge that ends the `load` pulse cycle; it is accepted in IDLE as normal.
- `busy` is decoded from the state register. It rises the cycle after the first accepted bit and falls in the same cycle `load`/`err` rises.
- Reset or `sync` mid-frame: the partial word is lost, and the next valid bit starts a fresh frame.
- Downstream register: `load` and `data` arrive together, so the register captures the word on the next edge.

## Configuration
- `S2P_PARITY_EN` defined: PAR state present; each frame is N data bits plus 1 even-parity bit; `err` is driven as described.
- `S2P_PARITY_EN` undefined: no PAR state; each frame is N data bits; `err` is tied to 0.

## Test plan
All cases use N=4.
- Reset, then `din` 1,0,1,1 on consecutive valid cycles → `load`=1 for exactly one cycle after the 4th bit, `data`=4'b1011, `busy` low again.
- Same bits with `din_valid` low for 3 cycles between bits 2 and 3 → identical result; `busy` stays high through the gap.
- Bits 1,1 then `sync`, then 0,1,1,0 → single `load` with `data`=4'b0110; no pulse at the `sync`.
- Two frames back-to-back (1,1,0,0 then 0,0,1,1) → two `load` pulses 4 cycles apart, `data`=4'b1100 then 4'b0011. Then `reset` after 2 bits of a third frame → `data`=0, `load`=0, `busy`=0.
- With `S2P_PARITY_EN`:
  - 1,0,1,1 plus parity 1 → `load`, `data`=4'b1011.
  - 1,0,1,1 plus parity 0 → `err` pulse, no `load`, `data` unchanged.
